// File: rtl/systolic_grid_os.sv
// systolic_grid_os
//   Output-stationary ROWS x COLS systolic grid of signed multiply-accumulate
//   PEs. One A column vector and one B row vector are accepted per beat; the
//   grid skews them internally so that beat k meets itself in PE(r,c) r+c+1
//   cycles after acceptance. After the inLast beat the pipeline is flushed for
//   ROWS+COLS-1 cycles and C is drained one row per handshake, bottom row first.
//
// Ports
//   clock, reset        sole clock; synchronous active-high reset
//   inValid/inReady     operand beat handshake, inLast marks beat K-1
//   aIn                 ROWS signed A elements, element r at [r*A_W +: A_W]
//   bIn                 COLS signed B elements, element c at [c*B_W +: B_W]
//   outValid/outReady   result row handshake, outLast marks the final row
//   cOut                one C row, element c at [c*ACC_W +: ACC_W]
//   overflow            sticky accumulate overflow flag for the current tile
//   busy                high whenever the grid is not idle
module systolic_grid_os #(
  parameter int ROWS     = 4,
  parameter int COLS     = 4,
  parameter int A_W      = 8,
  parameter int B_W      = 8,
  parameter int ACC_W    = 24,
  parameter int SATURATE = 1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    inValid,
  output logic                    inReady,
  input  logic                    inLast,
  input  logic [ROWS*A_W-1:0]     aIn,
  input  logic [COLS*B_W-1:0]     bIn,
  output logic                    outValid,
  input  logic                    outReady,
  output logic                    outLast,
  output logic [COLS*ACC_W-1:0]   cOut,
  output logic                    overflow,
  output logic                    busy
);

  localparam int P_W   = A_W + B_W;
  localparam int CNT_W = (ROWS + COLS > 2) ? $clog2(ROWS + COLS) : 1;
  localparam logic [CNT_W-1:0] FLUSH_END = CNT_W'(ROWS + COLS - 2);
  localparam logic [CNT_W-1:0] DRAIN_END = CNT_W'(ROWS - 1);
  localparam logic [ACC_W-1:0] ACC_MAX   = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN   = {1'b1, {(ACC_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DRAIN} stateT;

  stateT            state, stateNext;
  logic [CNT_W-1:0] cnt, cntNext;
  logic             accept;
  logic             drainFire;
  logic             ovfAny;

  // Operand pipelines: element [r][c] is the operand currently seen by PE(r,c)
  logic signed [A_W-1:0] aPipe  [ROWS][COLS];
  logic                  aPipeV [ROWS][COLS];
  logic signed [B_W-1:0] bPipe  [ROWS][COLS];
  logic                  bPipeV [ROWS][COLS];

  logic [ACC_W-1:0]      acc     [ROWS][COLS];
  logic [ACC_W-1:0]      accNext [ROWS][COLS];
  logic signed [P_W-1:0] prod    [ROWS][COLS];
  logic [ACC_W:0]        sumW    [ROWS][COLS];
  logic                  ovfPe   [ROWS][COLS];

  // Skew line outputs feeding column 0 (A) and row 0 (B)
  logic [ROWS*A_W-1:0] aEdge;
  logic [ROWS-1:0]     aEdgeV;
  logic [COLS*B_W-1:0] bEdge;
  logic [COLS-1:0]     bEdgeV;

  // ---------------------------------------------------------------- control
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= stateNext;
      cnt   <= cntNext;
    end
  end

  always_comb begin
    stateNext = state;
    cntNext   = cnt;
    inReady   = 1'b0;
    outValid  = 1'b0;
    outLast   = 1'b0;
    accept    = 1'b0;
    drainFire = 1'b0;
    busy      = (state != IDLE);
    case (state)
      IDLE: begin
        inReady = 1'b1;
        accept  = inValid;
        cntNext = '0;
        if (accept) stateNext = inLast ? FLUSH : LOAD;
      end
      LOAD: begin
        inReady = 1'b1;
        accept  = inValid;
        if (accept && inLast) begin
          stateNext = FLUSH;
          cntNext   = '0;
        end
      end
      FLUSH: begin
        if (cnt == FLUSH_END) begin
          stateNext = DRAIN;
          cntNext   = '0;
        end else begin
          cntNext = cnt + CNT_W'(1);
        end
      end
      DRAIN: begin
        outValid  = 1'b1;
        outLast   = (cnt == DRAIN_END);
        drainFire = outReady;
        if (drainFire) begin
          if (cnt == DRAIN_END) begin
            stateNext = IDLE;
            cntNext   = '0;
          end else begin
            cntNext = cnt + CNT_W'(1);
          end
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // ------------------------------------------------------------ input skew
  // Row r of A is delayed r cycles and column c of B c cycles before entering
  // the array, so both operands of beat k arrive at PE(r,c) together.
  for (genvar gr = 0; gr < ROWS; gr++) begin : gASkew
    if (gr == 0) begin : gDirect
      assign aEdge[0 +: A_W] = accept ? aIn[0 +: A_W] : '0;
      assign aEdgeV[0]       = accept;
    end else begin : gDelay
      logic [A_W-1:0] dly  [gr];
      logic           dlyV [gr];
      always_ff @(posedge clock) begin
        if (reset) begin
          for (int unsigned k = 0; k < gr; k++) begin
            dly[k]  <= '0;
            dlyV[k] <= 1'b0;
          end
        end else begin
          dly[0]  <= accept ? aIn[gr*A_W +: A_W] : '0;
          dlyV[0] <= accept;
          for (int unsigned k = 1; k < gr; k++) begin
            dly[k]  <= dly[k-1];
            dlyV[k] <= dlyV[k-1];
          end
        end
      end
      assign aEdge[gr*A_W +: A_W] = dly[gr-1];
      assign aEdgeV[gr]           = dlyV[gr-1];
    end
  end

  for (genvar gc = 0; gc < COLS; gc++) begin : gBSkew
    if (gc == 0) begin : gDirect
      assign bEdge[0 +: B_W] = accept ? bIn[0 +: B_W] : '0;
      assign bEdgeV[0]       = accept;
    end else begin : gDelay
      logic [B_W-1:0] dly  [gc];
      logic           dlyV [gc];
      always_ff @(posedge clock) begin
        if (reset) begin
          for (int unsigned k = 0; k < gc; k++) begin
            dly[k]  <= '0;
            dlyV[k] <= 1'b0;
          end
        end else begin
          dly[0]  <= accept ? bIn[gc*B_W +: B_W] : '0;
          dlyV[0] <= accept;
          for (int unsigned k = 1; k < gc; k++) begin
            dly[k]  <= dly[k-1];
            dlyV[k] <= dlyV[k-1];
          end
        end
      end
      assign bEdge[gc*B_W +: B_W] = dly[gc-1];
      assign bEdgeV[gc]           = dlyV[gc-1];
    end
  end

  // ---------------------------------------------------------- PE datapath
  // Sum is formed at ACC_W+1 bits; a disagreement between the top two bits
  // means the true sum left the ACC_W range.
  always_comb begin
    prod    = '{default: '0};
    sumW    = '{default: '0};
    accNext = '{default: '0};
    ovfPe   = '{default: 1'b0};
    ovfAny  = 1'b0;
    for (int unsigned r = 0; r < ROWS; r++) begin
      for (int unsigned c = 0; c < COLS; c++) begin
        prod[r][c]  = P_W'(aPipe[r][c]) * P_W'(bPipe[r][c]);
        sumW[r][c]  = {acc[r][c][ACC_W-1], acc[r][c]}
                    + {{(ACC_W+1-P_W){prod[r][c][P_W-1]}}, prod[r][c]};
        ovfPe[r][c] = sumW[r][c][ACC_W] ^ sumW[r][c][ACC_W-1];
        if (ovfPe[r][c] && (SATURATE != 0))
          accNext[r][c] = sumW[r][c][ACC_W] ? ACC_MIN : ACC_MAX;
        else
          accNext[r][c] = sumW[r][c][ACC_W-1:0];
        if (ovfPe[r][c] && aPipeV[r][c] && bPipeV[r][c]) ovfAny = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned r = 0; r < ROWS; r++) begin
        for (int unsigned c = 0; c < COLS; c++) begin
          aPipe[r][c]  <= '0;
          aPipeV[r][c] <= 1'b0;
          bPipe[r][c]  <= '0;
          bPipeV[r][c] <= 1'b0;
          acc[r][c]    <= '0;
        end
      end
      overflow <= 1'b0;
    end else begin
      for (int unsigned r = 0; r < ROWS; r++) begin
        aPipe[r][0]  <= aEdge[r*A_W +: A_W];
        aPipeV[r][0] <= aEdgeV[r];
        for (int unsigned c = 1; c < COLS; c++) begin
          aPipe[r][c]  <= aPipe[r][c-1];
          aPipeV[r][c] <= aPipeV[r][c-1];
        end
      end
      for (int unsigned c = 0; c < COLS; c++) begin
        bPipe[0][c]  <= bEdge[c*B_W +: B_W];
        bPipeV[0][c] <= bEdgeV[c];
        for (int unsigned r = 1; r < ROWS; r++) begin
          bPipe[r][c]  <= bPipe[r-1][c];
          bPipeV[r][c] <= bPipeV[r-1][c];
        end
      end
      // The flush guarantees no valid operands remain during DRAIN, so the
      // row shift never competes with an accumulate.
      if (drainFire) begin
        for (int unsigned c = 0; c < COLS; c++) begin
          acc[0][c] <= '0;
          for (int unsigned r = 1; r < ROWS; r++) acc[r][c] <= acc[r-1][c];
        end
      end else begin
        for (int unsigned r = 0; r < ROWS; r++) begin
          for (int unsigned c = 0; c < COLS; c++) begin
            if (aPipeV[r][c] && bPipeV[r][c]) acc[r][c] <= accNext[r][c];
          end
        end
      end
      if (state != IDLE && stateNext == IDLE) overflow <= 1'b0;
      else if (ovfAny)                        overflow <= 1'b1;
    end
  end

  // Bottom accumulator row is presented directly
  always_comb begin
    cOut = '0;
    for (int unsigned c = 0; c < COLS; c++) cOut[c*ACC_W +: ACC_W] = acc[ROWS-1][c];
  end

endmodule
